// File: rtl/vga_sprite_engine.sv
// vga_sprite_engine: N-slot sprite compositor for the 640x480 VGA path.
// Avalon-MM slave with double-buffered sprite registers that commit at
// vblank, a 3-cycle hit/ROM/priority pipeline, signed edge clipping and a
// sticky sprite-sprite collision detector.
//
// Optional build macro: SPRITE_MIRROR_EN adds a horizontal flip on ctrl bit1.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   chipselect, write,   Avalon-MM slave: 6-bit word address,
//   read, address,       16-bit write data,
//   writedata, readdata  registered read data (valid the cycle after a read)
//   hcount, vcount       raster position from vga_counters (col = hcount[10:1])
//   rom_addr             per-slot {img, row, col} sprite ROM address
//   rom_data             per-slot 4-bit palette index, 1-cycle synchronous ROM
//   pix_color            winning sprite palette index, 0 when none
//   pix_opaque           an opaque sprite pixel covers this position
//   coll_irq             OR of the sticky collision status bits
module vga_sprite_engine #(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned SPRITE_SIZE = 32,
  parameter int unsigned IMG_BITS    = 5,
  parameter int unsigned VACTIVE     = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [5:0]  address,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [NUM_SPRITES*(IMG_BITS+2*$clog2(SPRITE_SIZE))-1:0] rom_addr,
  input  logic [NUM_SPRITES*4-1:0] rom_data,
  output logic [3:0]  pix_color,
  output logic        pix_opaque,
  output logic        coll_irq
);

  localparam int unsigned SZ_BITS = $clog2(SPRITE_SIZE);
  localparam int unsigned AW      = IMG_BITS + 2 * SZ_BITS;
  localparam int unsigned N       = NUM_SPRITES;

  localparam logic [5:0] ADDR_COMMIT = 6'(4 * N);
  localparam logic [5:0] ADDR_COLL   = 6'(4 * N + 1);
  localparam logic [5:0] ADDR_FRAME  = 6'(4 * N + 2);

  localparam logic signed [11:0] HALF_S = 12'(SPRITE_SIZE / 2);
  localparam logic signed [11:0] SIZE_S = 12'(SPRITE_SIZE);

  // shadow (software-visible) and active (display) sprite registers
  logic [9:0]          x_sh   [N];
  logic [9:0]          y_sh   [N];
  logic [IMG_BITS-1:0] img_sh [N];
  logic [N-1:0]        en_sh;
  logic [9:0]          x_act  [N];
  logic [9:0]          y_act  [N];
  logic [IMG_BITS-1:0] img_act[N];
  logic [N-1:0]        en_act;
`ifdef SPRITE_MIRROR_EN
  logic [N-1:0]        mir_sh;
  logic [N-1:0]        mir_act;
`endif

  logic        commit_pending;
  logic [15:0] frame_cnt;
  logic [N-1:0] coll_status;

  logic wr, rd, vblank, commit_wr, coll_rd;

  assign wr        = chipselect & write;
  assign rd        = chipselect & read;
  assign vblank    = (vcount == 10'(VACTIVE)) && (hcount == 11'd0);
  assign commit_wr = wr && (address == ADDR_COMMIT) && writedata[0];
  assign coll_rd   = rd && (address == ADDR_COLL);

  // bits of the bus and raster inputs that no register consumes
  logic unused;
  assign unused = &{1'b0, hcount[0], writedata};

  // shadow register writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N); i++) begin
        x_sh[i]   <= '0;
        y_sh[i]   <= '0;
        img_sh[i] <= '0;
      end
      en_sh <= '0;
`ifdef SPRITE_MIRROR_EN
      mir_sh <= '0;
`endif
    end else if (wr) begin
      for (int i = 0; i < int'(N); i++) begin
        if (address == 6'(4 * i))     x_sh[i]   <= writedata[9:0];
        if (address == 6'(4 * i + 1)) y_sh[i]   <= writedata[9:0];
        if (address == 6'(4 * i + 2)) img_sh[i] <= writedata[IMG_BITS-1:0];
        if (address == 6'(4 * i + 3)) begin
          en_sh[i] <= writedata[0];
`ifdef SPRITE_MIRROR_EN
          mir_sh[i] <= writedata[1];
`endif
        end
      end
    end
  end

  // vblank commit of shadow to active, commit flag and frame counter;
  // a COMMIT write landing on the vblank cycle arms the following frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N); i++) begin
        x_act[i]   <= '0;
        y_act[i]   <= '0;
        img_act[i] <= '0;
      end
      en_act         <= '0;
`ifdef SPRITE_MIRROR_EN
      mir_act        <= '0;
`endif
      commit_pending <= 1'b0;
      frame_cnt      <= '0;
    end else begin
      if (vblank) begin
        frame_cnt <= frame_cnt + 16'd1;
        if (commit_pending) begin
          for (int i = 0; i < int'(N); i++) begin
            x_act[i]   <= x_sh[i];
            y_act[i]   <= y_sh[i];
            img_act[i] <= img_sh[i];
          end
          en_act  <= en_sh;
`ifdef SPRITE_MIRROR_EN
          mir_act <= mir_sh;
`endif
        end
        commit_pending <= commit_wr;
      end else if (commit_wr) begin
        commit_pending <= 1'b1;
      end
    end
  end

  // read mux; slot registers return shadow values
  logic [15:0] rd_val;
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (address[5:2] == 4'(i)) begin
        case (address[1:0])
          2'd0:    rd_val = 16'(x_sh[i]);
          2'd1:    rd_val = 16'(y_sh[i]);
          2'd2:    rd_val = 16'(img_sh[i]);
`ifdef SPRITE_MIRROR_EN
          default: rd_val = 16'({mir_sh[i], en_sh[i]});
`else
          default: rd_val = 16'(en_sh[i]);
`endif
        endcase
      end
    end
    if (address == ADDR_COLL)  rd_val = 16'(coll_status);
    if (address == ADDR_FRAME) rd_val = frame_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= rd ? rd_val : 16'd0;
  end

  // stage 0: signed hit test and ROM address; offsets are relative to the
  // sprite's top-left corner, so a negative corner clips instead of wrapping
  logic signed [11:0] col_s, row_s;
  logic signed [11:0] dx_s [N];
  logic signed [11:0] dy_s [N];
  logic [N-1:0]       hit0;
  logic [AW-1:0]      addr0 [N];
  logic [SZ_BITS-1:0] cidx;

  always_comb begin
    col_s = $signed({2'b00, hcount[10:1]});
    row_s = $signed({2'b00, vcount});
    cidx  = '0;
    for (int i = 0; i < int'(N); i++) begin
      dx_s[i] = col_s - ($signed({2'b00, x_act[i]}) - HALF_S);
      dy_s[i] = row_s - ($signed({2'b00, y_act[i]}) - HALF_S);
      hit0[i] = en_act[i] &&
                (dx_s[i] >= 12'sd0) && (dx_s[i] < SIZE_S) &&
                (dy_s[i] >= 12'sd0) && (dy_s[i] < SIZE_S);
      cidx = dx_s[i][SZ_BITS-1:0];
`ifdef SPRITE_MIRROR_EN
      if (mir_act[i]) cidx = ~cidx;
`endif
      addr0[i] = hit0[i] ? {img_act[i], dy_s[i][SZ_BITS-1:0], cidx} : '0;
    end
  end

  // stage 3: priority select (lowest slot wins) and collision detect
  logic [N-1:0] hit1, hit2, opq;
  logic [3:0]   win_color;
  logic         win_valid;
  logic [N-1:0] coll_next;

  always_comb begin
    win_color = '0;
    win_valid = 1'b0;
    for (int i = 0; i < int'(N); i++)
      opq[i] = hit2[i] && (rom_data[i*4 +: 4] != 4'd0);
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (opq[i]) begin
        win_color = rom_data[i*4 +: 4];
        win_valid = 1'b1;
      end
    end
    // more than one bit set: clearing the lowest set bit leaves something
    coll_next = (coll_rd ? '0 : coll_status) |
                (((opq & (opq - N'(1))) != '0) ? opq : '0);
  end

  // pipeline registers: stage 1 ROM address, stage 2 hit alignment with
  // ROM data, stage 3 outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr    <= '0;
      hit1        <= '0;
      hit2        <= '0;
      pix_color   <= '0;
      pix_opaque  <= 1'b0;
      coll_status <= '0;
      coll_irq    <= 1'b0;
    end else begin
      for (int i = 0; i < int'(N); i++)
        rom_addr[i*AW +: AW] <= addr0[i];
      hit1        <= hit0;
      hit2        <= hit1;
      pix_color   <= win_color;
      pix_opaque  <= win_valid;
      coll_status <= coll_next;
      coll_irq    <= |coll_next;
    end
  end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Self-checking bench for vga_sprite_engine: directed scenarios plus random
// traffic, all compared against a frame/pixel-level reference model.
`timescale 1ns/1ps
module tb_vga_sprite_engine;

  localparam int N  = 4;
  localparam int SZ = 32;
  localparam int IB = 5;
  localparam int SB = 5;
  localparam int AW = IB + 2 * SB;
  localparam int H  = SZ / 2;
  localparam int A_COMMIT = 4 * N;
  localparam int A_COLL   = 4 * N + 1;
  localparam int A_FRAME  = 4 * N + 2;
`ifdef SPRITE_MIRROR_EN
  localparam bit MIR = 1'b1;
`else
  localparam bit MIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          chipselect, write, read;
  logic [5:0]    address;
  logic [15:0]   writedata;
  logic [15:0]   readdata;
  logic [10:0]   hcount;
  logic [9:0]    vcount;
  logic [N*AW-1:0] rom_addr;
  logic [N*4-1:0]  rom_data;
  logic [3:0]    pix_color;
  logic          pix_opaque;
  logic          coll_irq;

  vga_sprite_engine #(.NUM_SPRITES(N), .SPRITE_SIZE(SZ), .IMG_BITS(IB), .VACTIVE(480)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .hcount(hcount), .vcount(vcount), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_color(pix_color), .pix_opaque(pix_opaque), .coll_irq(coll_irq)
  );

  always #10 clk = ~clk;

  // sprite ROM: img0 fully transparent, img1 fully opaque, others mixed
  logic [3:0] rom_mem [0:32767];
  always @(posedge clk)
    for (int i = 0; i < N; i++) rom_data[i*4 +: 4] <= rom_mem[rom_addr[i*AW +: AW]];

  int tests = 0;
  int fails = 0;

  // reference model state
  int sh_x[N], sh_y[N], sh_img[N], ac_x[N], ac_y[N], ac_img[N];
  bit sh_en[N], sh_mir[N], ac_en[N], ac_mir[N];
  bit pend;
  int fcnt;
  logic [N-1:0] stat;

  typedef struct {
    logic [3:0]   c;
    bit           o;
    logic [N-1:0] k;
  } pix_t;
  pix_t pq[$];

  function automatic void model_reset();
    pix_t z;
    for (int i = 0; i < N; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_img[i] = 0; sh_en[i] = 0; sh_mir[i] = 0;
      ac_x[i] = 0; ac_y[i] = 0; ac_img[i] = 0; ac_en[i] = 0; ac_mir[i] = 0;
    end
    pend = 0; fcnt = 0; stat = '0;
    z.c = '0; z.o = 0; z.k = '0;
    pq.delete();
    pq.push_back(z);
    pq.push_back(z);
  endfunction

  // what the mixer should see for pixel (col,row) given the active registers
  function automatic void model_pixel(input int col, input int row, output pix_t p);
    int dx, dy, cx, cnt;
    logic [3:0] d;
    logic [N-1:0] m;
    p.c = '0; p.o = 0; p.k = '0; cnt = 0; m = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (ac_en[i] && col >= ac_x[i] - H && col < ac_x[i] + H &&
          row >= ac_y[i] - H && row < ac_y[i] + H) begin
        dx = col - (ac_x[i] - H);
        dy = row - (ac_y[i] - H);
        cx = (MIR && ac_mir[i]) ? SZ - 1 - dx : dx;
        d  = rom_mem[ac_img[i] * 1024 + dy * 32 + cx];
        if (d != 4'd0) begin
          m[i] = 1'b1; cnt++; p.c = d; p.o = 1;
        end
      end
    end
    if (cnt >= 2) p.k = m;
  endfunction

  function automatic logic [15:0] model_read(input int a);
    if (a < 4 * N) begin
      case (a % 4)
        0: return 16'(sh_x[a / 4]);
        1: return 16'(sh_y[a / 4]);
        2: return 16'(sh_img[a / 4]);
        default: return {14'd0, sh_mir[a / 4] & MIR, sh_en[a / 4]};
      endcase
    end
    if (a == A_COLL)  return 16'(stat);
    if (a == A_FRAME) return 16'(fcnt);
    return 16'd0;
  endfunction

  // one clock: drive raster position and optional bus access, then check
  task automatic step(input int h, input int v, input bit w, input bit r, input int a, input int d);
    pix_t p, e;
    logic [15:0] exp_rd;
    bit vb, cw;
    hcount = 11'(h); vcount = 10'(v);
    chipselect = w | r; write = w; read = r;
    address = 6'(a); writedata = 16'(d);
    model_pixel(h / 2, v, p);
    exp_rd = model_read(a);
    @(posedge clk); #1;
    pq.push_back(p);
    e = pq.pop_front();
    stat = ((r && a == A_COLL) ? '0 : stat) | e.k;
    vb = (v == 480 && h == 0);
    cw = w && a == A_COMMIT && d[0];
    if (vb) begin
      fcnt = (fcnt + 1) & 16'hFFFF;
      if (pend) begin
        for (int i = 0; i < N; i++) begin
          ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_img[i] = sh_img[i];
          ac_en[i] = sh_en[i]; ac_mir[i] = sh_mir[i];
        end
      end
      pend = cw;
    end else if (cw) pend = 1;
    if (w && a < 4 * N) begin
      case (a % 4)
        0: sh_x[a / 4] = d & 16'h3FF;
        1: sh_y[a / 4] = d & 16'h3FF;
        2: sh_img[a / 4] = d & 31;
        default: begin sh_en[a / 4] = d[0]; sh_mir[a / 4] = MIR & d[1]; end
      endcase
    end
    tests++;
    if (pix_color !== e.c || pix_opaque !== e.o) begin
      fails++;
      $display("FAIL pix h=%0d v=%0d got color=%0d opaque=%0d want color=%0d opaque=%0d",
               h, v, pix_color, pix_opaque, e.c, e.o);
    end
    tests++;
    if (coll_irq !== (|stat)) begin
      fails++;
      $display("FAIL coll_irq got=%0d want=%0d", coll_irq, |stat);
    end
    if (r) begin
      tests++;
      if (readdata !== exp_rd) begin
        fails++;
        $display("FAIL readdata addr=%0d got=0x%04h want=0x%04h", a, readdata, exp_rd);
      end
    end
    chipselect = 0; write = 0; read = 0;
  endtask

  task automatic wr_reg(input int a, input int d); step(0, 500, 1, 0, a, d); endtask
  task automatic rd_reg(input int a); step(0, 500, 0, 1, a, 0); endtask
  task automatic pix(input int h, input int v); step(h, v, 0, 0, 0, 0); endtask
  task automatic vblank(); step(0, 480, 0, 0, 0, 0); endtask
  task automatic idle(); step(0, 500, 0, 0, 0, 0); endtask

  task automatic set_slot(input int s, input int x, input int y, input int img, input int ctrl);
    wr_reg(4 * s, x); wr_reg(4 * s + 1, y); wr_reg(4 * s + 2, img); wr_reg(4 * s + 3, ctrl);
  endtask

  task automatic check_zero_outputs(input string tag);
    tests++;
    if (readdata !== 16'd0 || pix_opaque !== 1'b0 || pix_color !== 4'd0 ||
        coll_irq !== 1'b0 || rom_addr !== '0) begin
      fails++;
      $display("FAIL %s got rd=0x%04h opq=%0d col=%0d irq=%0d rom=0x%0h want all zero",
               tag, readdata, pix_opaque, pix_color, coll_irq, rom_addr);
    end
  endtask

  task automatic test_reset();
    reset = 1; chipselect = 0; write = 0; read = 0; address = '0; writedata = '0;
    hcount = '0; vcount = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset_initial");
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
    set_slot(0, 100, 100, 1, 1);
    wr_reg(A_COMMIT, 1);
    vblank();
    for (int i = 0; i < 4; i++) pix(200 + i, 100);
    // reset mid-line with the sprite showing
    #5 reset = 1;
    #1 check_zero_outputs("reset_midline");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
    rd_reg(0); rd_reg(1); rd_reg(3); rd_reg(A_FRAME); rd_reg(A_COLL);
    for (int i = 0; i < 5; i++) pix(200 + i, 100);
  endtask

  task automatic test_commit();
    set_slot(0, 100, 100, 1, 1);
    wr_reg(A_COMMIT, 1);
    pix(168, 84); idle(); idle();
    tests++;
    if (pix_opaque !== 1'b0) begin
      fails++; $display("FAIL precommit_opaque got=%0d want=0", pix_opaque);
    end
    vblank();
    pix(166, 84); pix(168, 84); idle();
    tests++;
    if (pix_opaque !== 1'b0) begin
      fails++; $display("FAIL col83_opaque got=%0d want=0", pix_opaque);
    end
    idle();
    tests++;
    if (pix_opaque !== 1'b1 || pix_color !== rom_mem[1024]) begin
      fails++;
      $display("FAIL col84_first got opq=%0d col=%0d want opq=1 col=%0d",
               pix_opaque, pix_color, rom_mem[1024]);
    end
    for (int c = 112; c <= 118; c++) pix(2 * c, 115);
    idle(); idle();
  endtask

  task automatic test_no_commit();
    wr_reg(0, 300);
    wr_reg(1, 200);
    for (int f = 0; f < 3; f++) begin
      vblank();
      pix(200, 100); pix(600, 200); pix(2 * 100, 90); idle(); idle();
    end
    rd_reg(0); rd_reg(1);
  endtask

  task automatic test_overlap();
    set_slot(0, 100, 100, 1, 1);
    set_slot(1, 110, 100, 1, 1);
    wr_reg(A_COMMIT, 1);
    vblank();
    pix(210, 100); idle(); idle();
    tests++;
    if (pix_color !== rom_mem[1 * 1024 + 16 * 32 + 21] || coll_irq !== 1'b1) begin
      fails++;
      $display("FAIL overlap got col=%0d irq=%0d want col=%0d irq=1",
               pix_color, coll_irq, rom_mem[1 * 1024 + 16 * 32 + 21]);
    end
    rd_reg(A_COLL);
    tests++;
    if (readdata !== 16'h0003) begin
      fails++; $display("FAIL coll_first got=0x%04h want=0x0003", readdata);
    end
    pix(180, 100); idle(); idle();
    rd_reg(A_COLL);
    tests++;
    if (readdata !== 16'h0000) begin
      fails++; $display("FAIL coll_second got=0x%04h want=0x0000", readdata);
    end
  endtask

  task automatic test_clip();
    int seen;
    set_slot(0, 5, 200, 0, 1);
    wr_reg(7, 0);
    set_slot(2, 5, 200, 1, 1);
    wr_reg(A_COMMIT, 1);
    vblank();
    seen = 0;
    for (int c = 0; c < 26; c++) begin pix(2 * c, 200); seen += pix_opaque; end
    for (int c = 612; c < 640; c++) begin pix(2 * c, 200); seen += pix_opaque; end
    for (int i = 0; i < 3; i++) begin idle(); seen += pix_opaque; end
    tests++;
    if (seen !== 21) begin
      fails++; $display("FAIL clip_count got=%0d want=21", seen);
    end
  endtask

  task automatic test_mirror();
    logic [AW-1:0] want;
    set_slot(3, 300, 300, 2, 3);
    wr_reg(A_COMMIT, 1);
    vblank();
    pix(2 * 284, 300);
    want = {5'd2, 5'd16, (MIR ? 5'd31 : 5'd0)};
    tests++;
    if (rom_addr[3*AW +: AW] !== want) begin
      fails++; $display("FAIL mirror_addr got=0x%0h want=0x%0h", rom_addr[3*AW +: AW], want);
    end
    for (int c = 284; c < 290; c++) pix(2 * c, 301);
    rd_reg(15);
    tests++;
    if (readdata !== (MIR ? 16'h0003 : 16'h0001)) begin
      fails++; $display("FAIL ctrl_readback got=0x%04h want=0x%04h", readdata, MIR ? 16'h0003 : 16'h0001);
    end
  endtask

  task automatic test_random();
    int op, a, d, h, v;
    for (int n = 0; n < 4000; n++) begin
      op = $urandom_range(0, 99);
      h = $urandom_range(0, 241);
      v = $urandom_range(0, 120);
      if (op < 60) begin
        pix(h, v);
      end else if (op < 75) begin
        a = $urandom_range(0, 4 * N - 1);
        case (a % 4)
          0, 1: d = $urandom_range(0, 110) | ($urandom_range(0, 63) << 10);
          2: d = $urandom_range(0, 65535);
          default: d = $urandom_range(0, 65535);
        endcase
        if ($urandom_range(0, 19) == 0) a = $urandom_range(19, 63);
        step(h, v, 1, 0, a, d);
      end else if (op < 80) begin
        step(h, v, 1, 0, A_COMMIT, $urandom_range(0, 3));
      end else if (op < 92) begin
        a = $urandom_range(0, 4 * N + 6);
        if (a == A_COMMIT) a = A_COLL;
        if (a > A_FRAME) a = $urandom_range(19, 63);
        step(h, v, 0, 1, a, 0);
      end else if (op < 96) begin
        step(0, 480, $urandom_range(0, 1), 0, A_COMMIT, 1);
      end else begin
        vblank();
      end
    end
    rd_reg(A_FRAME);
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32768; i++) begin
      if (i < 1024)      rom_mem[i] = 4'd0;
      else if (i < 2048) rom_mem[i] = 4'($urandom_range(1, 15));
      else               rom_mem[i] = ($urandom_range(0, 9) < 3) ? 4'd0 : 4'($urandom_range(1, 15));
    end
    test_reset();
    test_commit();
    test_no_commit();
    test_overlap();
    test_clip();
    test_mirror();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
